id_operand_stage: RTL and testbench
===================================

Name: id_operand_stage

Overview:
Parametrised decode-stage front end for the 5-stage MIPS pipeline. Holds the IF->ID pipeline register under a valid/allowin handshake and fetches both source operands. Operands come from the register file or from NUM_FWD bypass channels, with a load-use interlock and a saturating stall counter. Sits between IF and the decode/EXE issue logic, replacing the fixed 2-bit forwarding-select scheme.

Parameters:
XLEN, 32, datapath width of PC, instruction and operands
NUM_FWD, 3, number of bypass channels; index 0 is the youngest producer (EXE)
RESET_PC, 32'hbfc00000, ID pc value after reset
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
flush  in  1  kill ID contents (branch/exception redirect)
if_valid  in  1  IF presents an instruction
if_pc  in  XLEN  IF pc
if_inst  in  32  IF instruction
id_allowin  out  1  ID accepts an instruction this cycle
exe_allowin  in  1  EXE accepts this cycle
id_to_exe_valid  out  1  ID presents a resolved instruction
id_pc  out  XLEN  registered pc
id_inst  out  32  registered instruction
reg_raddr1  out  5  regfile port 1 address (rs or 0)
reg_raddr2  out  5  regfile port 2 address (rt or 0)
reg_rdata1  in  XLEN  regfile port 1 data (combinational)
reg_rdata2  in  XLEN  regfile port 2 data (combinational)
fwd_valid  in  NUM_FWD  channel holds a live instruction writing a GPR
fwd_dest  in  5*NUM_FWD  channel destination register, packed, channel i at [5i+4:5i]
fwd_ready  in  NUM_FWD  channel result is available this cycle
fwd_data  in  XLEN*NUM_FWD  channel result, packed
id_vsrc1  out  XLEN  resolved rs value
id_vsrc2  out  XLEN  resolved rt value
id_hazard  out  1  operand not yet available
stall_cnt  out  CNT_W  count of cycles lost to hazards

Behaviour:
- Reset (resetn=0 at a clk edge):
  - id_valid=0, id_pc=RESET_PC, id_inst=0, stall_cnt=0.
  - All outputs derived from these follow combinationally: id_to_exe_valid=0, id_hazard=0, id_allowin=1.
- Source usage (sub-decoder):
  - rs is used unless the opcode is J, JAL or LUI, or the instruction is SLL/SRL/SRA.
  - rt is used for SPECIAL R-type, BEQ/BNE, stores, LWL/LWR, and MTC0-free SPECIAL moves with rt.
  - Unused sources drive address 0.
- Operand resolution, per source, combinational:
  - If the address is 0, the value is 0 and there is no hazard.
  - Otherwise, scan channels 0..NUM_FWD-1. The first channel with fwd_valid=1 and a matching fwd_dest wins.
  - If the winning channel has fwd_ready=1, the value is that channel's fwd_data. If fwd_ready=0, id_hazard is set.
  - If no channel matches, the value is reg_rdata.
  - Older channels are never used when a younger one matches.
- Handshake:
  - ready_go = !id_hazard.
  - id_allowin = !id_valid | (ready_go & exe_allowin).
  - id_to_exe_valid = id_valid & ready_go & !flush.
- Register update at the clk edge, first matching rule wins:
  - Reset.
  - flush: id_valid<=0; pc and inst are don't-care-held.
  - id_allowin: id_valid<=if_valid; when if_valid=1, load if_pc and if_inst.
  - Otherwise, hold.
- Latency: an instruction accepted at edge N is offered to EXE in cycle N, and leaves at edge N+1 when there is no hazard and exe_allowin=1.
- Stall counter:
  - Increments when id_valid & id_hazard & !flush.
  - Saturates at all-ones; no wrap.
- Simultaneous events:
  - flush together with if_valid: the fetched instruction is dropped.
  - A hazard together with exe_allowin=0: hold; count the cycle only if id_hazard=1.
  - A reset during a stall clears everything, including the counter.

Decomposition:
- Shared package (head.h): opcode/funct constants (SPECIAL, J, JAL, LUI, BEQ, BNE, SB/SH/SW/SWL/SWR, LWL, LWR, SLL_2/SRL_2/SRA_2) and the RESET_PC constant.
- Sub-module id_src_decode: combinational, inst[31:0] -> rs_used, rt_used. The operand resolver is generated twice, in a generate loop over sources.

Test Plan:
- Reset, then if_valid=1 with pc=0xbfc00004 and inst ADDU $3,$1,$2 (reg1=5, reg2=7, no forwards) -> next cycle id_to_exe_valid=1, id_vsrc1=5, id_vsrc2=7, id_allowin=1.
- Channels 0 and 2 both valid with dest=1 and ready, data 0x11 / 0x22 -> id_vsrc1=0x11 (youngest wins). Same case with channel 0 invalid -> 0x22.
- Load in channel 0 with dest=2, fwd_ready=0, ID holds ADDU using $2 -> id_hazard=1, id_to_exe_valid=0, id_allowin=0, stall_cnt increments each cycle. Raise fwd_ready with data 0x99 -> id_vsrc2=0x99, issues that cycle.
- Channel matches dest=0 with data 0xdead, instruction reads $0 -> id_vsrc=0, no hazard.
- flush asserted with if_valid=1 while stalled -> next cycle id_valid=0, id_to_exe_valid=0, stall_cnt unchanged on the flush cycle.
- CNT_W=4, hazard held for 20 cycles -> stall_cnt saturates at 15; resetn=0 -> 0.

Source files
------------

// File: rtl/id_operand_stage_pkg.sv
// Shared decode constants for the ID operand stage: MIPS opcode/funct
// encodings needed by the source-usage decoder, plus the boot PC.
package id_operand_stage_pkg;

   localparam logic [31:0] PKG_RESET_PC = 32'hbfc00000;

   typedef enum logic [5:0] {
      OP_SPECIAL = 6'h00,
      OP_J       = 6'h02,
      OP_JAL     = 6'h03,
      OP_BEQ     = 6'h04,
      OP_BNE     = 6'h05,
      OP_LUI     = 6'h0f,
      OP_LWL     = 6'h22,
      OP_LWR     = 6'h26,
      OP_SB      = 6'h28,
      OP_SH      = 6'h29,
      OP_SWL     = 6'h2a,
      OP_SW      = 6'h2b,
      OP_SWR     = 6'h2e
   } opcode_e;

   // Immediate-shift functs under SPECIAL: these read rt and shamt, never rs.
   localparam logic [5:0] FN_SLL_2 = 6'h00;
   localparam logic [5:0] FN_SRL_2 = 6'h02;
   localparam logic [5:0] FN_SRA_2 = 6'h03;

   typedef enum logic {
      SRC_RS = 1'b0,
      SRC_RT = 1'b1
   } src_e;

endpackage

// File: rtl/id_operand_stage_src_decode.sv
// Source-usage sub-decoder: tells the operand stage which of rs/rt an
// instruction actually reads, so unused sources never raise a hazard.
module id_src_decode
   import id_operand_stage_pkg::*;
(
   input  logic [31:0] inst,
   output logic        rs_used,
   output logic        rt_used
);

   logic [5:0] op;
   logic [5:0] funct;
   logic       unused_inst_bits;

   assign op               = inst[31:26];
   assign funct            = inst[5:0];
   assign unused_inst_bits = ^inst[25:6];

   // Classify the instruction by opcode (and funct for SPECIAL).
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      rs_used = 1'b1;
      rt_used = 1'b0;
      unique case (op)
         OP_J, OP_JAL, OP_LUI: rs_used = 1'b0;
         OP_SPECIAL: begin
            rt_used = 1'b1;
            if (funct == FN_SLL_2 || funct == FN_SRL_2 || funct == FN_SRA_2)
               rs_used = 1'b0;
         end
         OP_BEQ, OP_BNE,
         OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR,
         OP_LWL, OP_LWR: rt_used = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/id_operand_stage.sv
// ID-stage front end: IF->ID pipeline register under valid/allowin,
// operand fetch from the regfile or NUM_FWD bypass channels (channel 0 is
// youngest), load-use interlock and a saturating stall-cycle counter.
module id_operand_stage
   import id_operand_stage_pkg::*;
#(
   parameter int               XLEN     = 32,
   parameter int               NUM_FWD  = 3,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(PKG_RESET_PC),
   parameter int               CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  flush,
   input  logic                  if_valid,
   input  logic [XLEN-1:0]       if_pc,
   input  logic [31:0]           if_inst,
   output logic                  id_allowin,
   input  logic                  exe_allowin,
   output logic                  id_to_exe_valid,
   output logic [XLEN-1:0]       id_pc,
   output logic [31:0]           id_inst,
   output logic [4:0]            reg_raddr1,
   output logic [4:0]            reg_raddr2,
   input  logic [XLEN-1:0]       reg_rdata1,
   input  logic [XLEN-1:0]       reg_rdata2,
   input  logic [NUM_FWD-1:0]    fwd_valid,
   input  logic [5*NUM_FWD-1:0]  fwd_dest,
   input  logic [NUM_FWD-1:0]    fwd_ready,
   input  logic [XLEN*NUM_FWD-1:0] fwd_data,
   output logic [XLEN-1:0]       id_vsrc1,
   output logic [XLEN-1:0]       id_vsrc2,
   output logic                  id_hazard,
   output logic [CNT_W-1:0]      stall_cnt
);

   logic              id_valid_q, id_valid_d;
   logic [XLEN-1:0]   id_pc_q,    id_pc_d;
   logic [31:0]       id_inst_q,  id_inst_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic              rs_used, rt_used;
   logic              ready_go;
   logic [9:0]        src_addr;
   logic [2*XLEN-1:0] src_rdata;
   logic [2*XLEN-1:0] src_val;
   logic [1:0]        src_hazard;

   id_src_decode u_src_decode (
      .inst    (id_inst_q),
      .rs_used (rs_used),
      .rt_used (rt_used)
   );

   assign reg_raddr1 = rs_used ? id_inst_q[25:21] : 5'd0;
   assign reg_raddr2 = rt_used ? id_inst_q[20:16] : 5'd0;

   assign src_addr  = {reg_raddr2, reg_raddr1};
   assign src_rdata = {reg_rdata2, reg_rdata1};

   for (genvar s = 0; s < 2; s++) begin : g_src
      logic [4:0]      addr;
      logic [XLEN-1:0] val;
      logic            haz;

      assign addr = src_addr[5*s +: 5];

      // Resolve one source: $0 is constant zero, else youngest matching channel, else regfile.
      always_comb begin
         logic hit;
         val = src_rdata[XLEN*s +: XLEN];
         haz = 1'b0;
         hit = 1'b0;
         if (addr == 5'd0) begin
            val = '0;
         end else begin
            for (int c = 0; c < NUM_FWD; c++) begin
               if (!hit && fwd_valid[c] && fwd_dest[5*c +: 5] == addr) begin
                  hit = 1'b1;
                  if (fwd_ready[c]) val = fwd_data[XLEN*c +: XLEN];
                  else              haz = 1'b1;
               end
            end
         end
      end

      assign src_val[XLEN*s +: XLEN] = val;
      assign src_hazard[s]           = haz;
   end

   assign id_vsrc1 = src_val[XLEN*SRC_RS +: XLEN];
   assign id_vsrc2 = src_val[XLEN*SRC_RT +: XLEN];

   assign id_hazard       = id_valid_q & (|src_hazard);
   assign ready_go        = !id_hazard;
   assign id_allowin      = !id_valid_q | (ready_go & exe_allowin);
   assign id_to_exe_valid = id_valid_q & ready_go & !flush;

   assign id_pc     = id_pc_q;
   assign id_inst   = id_inst_q;
   assign stall_cnt = stall_cnt_q;

   // Next-state for the pipeline register and the saturating stall counter.
   always_comb begin
      id_valid_d  = id_valid_q;
      id_pc_d     = id_pc_q;
      id_inst_d   = id_inst_q;
      stall_cnt_d = stall_cnt_q;

      if (flush) begin
         id_valid_d = 1'b0;
      end else if (id_allowin) begin
         id_valid_d = if_valid;
         if (if_valid) begin
            id_pc_d   = if_pc;
            id_inst_d = if_inst;
         end
      end

      if (id_valid_q && id_hazard && !flush && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (!resetn) begin
         id_valid_q  <= 1'b0;
         id_pc_q     <= RESET_PC;
         id_inst_q   <= 32'd0;
         stall_cnt_q <= '0;
      end else begin
         id_valid_q  <= id_valid_d;
         id_pc_q     <= id_pc_d;
         id_inst_q   <= id_inst_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: a default instance and a CNT_W=4
// instance share all stimulus so counter saturation is visible.
module tb_id_operand_stage;

   localparam int XLEN = 32;
   localparam int NF   = 3;

   localparam logic [31:0] ADDU_3_1_2 = 32'h00221821;
   localparam logic [31:0] ADDU_3_0_0 = 32'h00001821;

   logic            clk = 1'b0;
   logic            resetn, flush, if_valid, exe_allowin;
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_inst;
   logic [NF-1:0]   fwd_valid, fwd_ready;
   logic [5*NF-1:0] fwd_dest;
   logic [XLEN*NF-1:0] fwd_data;

   logic            id_allowin, id_to_exe_valid, id_hazard;
   logic [XLEN-1:0] id_pc, id_vsrc1, id_vsrc2, reg_rdata1, reg_rdata2;
   logic [31:0]     id_inst;
   logic [4:0]      reg_raddr1, reg_raddr2;
   logic [15:0]     stall_cnt;

   logic            s_allowin, s_to_exe_valid, s_hazard;
   logic [XLEN-1:0] s_pc, s_vsrc1, s_vsrc2, s_rdata1, s_rdata2;
   logic [31:0]     s_inst;
   logic [4:0]      s_raddr1, s_raddr2;
   logic [3:0]      s_stall_cnt;

   logic [XLEN-1:0] regs [32];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Regfile stub: fixed contents, combinational read.
   assign reg_rdata1 = regs[reg_raddr1];
   assign reg_rdata2 = regs[reg_raddr2];
   assign s_rdata1   = regs[s_raddr1];
   assign s_rdata2   = regs[s_raddr2];

   id_operand_stage #(.XLEN(XLEN), .NUM_FWD(NF)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .if_valid(if_valid),
      .if_pc(if_pc), .if_inst(if_inst), .id_allowin(id_allowin),
      .exe_allowin(exe_allowin), .id_to_exe_valid(id_to_exe_valid),
      .id_pc(id_pc), .id_inst(id_inst), .reg_raddr1(reg_raddr1),
      .reg_raddr2(reg_raddr2), .reg_rdata1(reg_rdata1), .reg_rdata2(reg_rdata2),
      .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_ready(fwd_ready),
      .fwd_data(fwd_data), .id_vsrc1(id_vsrc1), .id_vsrc2(id_vsrc2),
      .id_hazard(id_hazard), .stall_cnt(stall_cnt)
   );

   id_operand_stage #(.XLEN(XLEN), .NUM_FWD(NF), .CNT_W(4)) dut_small (
      .clk(clk), .resetn(resetn), .flush(flush), .if_valid(if_valid),
      .if_pc(if_pc), .if_inst(if_inst), .id_allowin(s_allowin),
      .exe_allowin(exe_allowin), .id_to_exe_valid(s_to_exe_valid),
      .id_pc(s_pc), .id_inst(s_inst), .reg_raddr1(s_raddr1),
      .reg_raddr2(s_raddr2), .reg_rdata1(s_rdata1), .reg_rdata2(s_rdata2),
      .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_ready(fwd_ready),
      .fwd_data(fwd_data), .id_vsrc1(s_vsrc1), .id_vsrc2(s_vsrc2),
      .id_hazard(s_hazard), .stall_cnt(s_stall_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_chan(input int c, input logic v, input logic [4:0] d,
                           input logic r, input logic [XLEN-1:0] data);
      fwd_valid[c]          = v;
      fwd_dest[5*c +: 5]    = d;
      fwd_ready[c]          = r;
      fwd_data[XLEN*c +: XLEN] = data;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = '0;
      regs[1] = 32'd5;
      regs[2] = 32'd7;

      resetn = 1'b0; flush = 1'b0; if_valid = 1'b0; exe_allowin = 1'b1;
      if_pc = '0; if_inst = '0;
      fwd_valid = '0; fwd_ready = '0; fwd_dest = '0; fwd_data = '0;
      step(2);

      // Reset state
      chk("rst_to_exe_valid", 64'(id_to_exe_valid), 64'd0);
      chk("rst_hazard",       64'(id_hazard),       64'd0);
      chk("rst_allowin",      64'(id_allowin),      64'd1);
      chk("rst_pc",           64'(id_pc),           64'hbfc00000);
      chk("rst_inst",         64'(id_inst),         64'd0);
      chk("rst_stall_cnt",    64'(stall_cnt),       64'd0);

      // Accept ADDU $3,$1,$2 from regfile
      resetn = 1'b1; if_valid = 1'b1; if_pc = 32'hbfc00004; if_inst = ADDU_3_1_2;
      step();
      if_valid = 1'b0;
      chk("addu_to_exe_valid", 64'(id_to_exe_valid), 64'd1);
      chk("addu_vsrc1",        64'(id_vsrc1),        64'd5);
      chk("addu_vsrc2",        64'(id_vsrc2),        64'd7);
      chk("addu_allowin",      64'(id_allowin),      64'd1);
      chk("addu_pc",           64'(id_pc),           64'hbfc00004);
      chk("addu_raddr1",       64'(reg_raddr1),      64'd1);
      chk("addu_raddr2",       64'(reg_raddr2),      64'd2);

      // Hold in ID; forwarding priority checks are purely combinational
      exe_allowin = 1'b0;
      set_chan(0, 1'b1, 5'd1, 1'b1, 32'h11);
      set_chan(2, 1'b1, 5'd1, 1'b1, 32'h22);
      #1;
      chk("fwd_youngest_wins", 64'(id_vsrc1), 64'h11);
      chk("fwd_rt_regfile",    64'(id_vsrc2), 64'd7);
      chk("hold_allowin",      64'(id_allowin), 64'd0);
      fwd_valid[0] = 1'b0;
      #1;
      chk("fwd_older_used", 64'(id_vsrc1), 64'h22);
      set_chan(0, 1'b1, 5'd1, 1'b1, 32'h11);
      set_chan(1, 1'b1, 5'd1, 1'b0, 32'h33);
      #1;
      chk("fwd_young_ready_masks_old_pending", 64'(id_hazard), 64'd0);
      chk("fwd_young_ready_val", 64'(id_vsrc1), 64'h11);

      // Load-use: channel 0 writes $2, not ready
      fwd_valid = '0;
      set_chan(0, 1'b1, 5'd2, 1'b0, 32'h0);
      exe_allowin = 1'b1;
      #1;
      chk("lu_hazard",       64'(id_hazard),       64'd1);
      chk("lu_to_exe_valid", 64'(id_to_exe_valid), 64'd0);
      chk("lu_allowin",      64'(id_allowin),      64'd0);
      step();
      chk("lu_cnt1", 64'(stall_cnt), 64'd1);
      step();
      chk("lu_cnt2", 64'(stall_cnt), 64'd2);
      step();
      chk("lu_cnt3", 64'(stall_cnt), 64'd3);
      chk("lu_pc_held", 64'(id_pc), 64'hbfc00004);

      // Load result arrives: issues this cycle, next instruction enters
      fwd_ready[0] = 1'b1; fwd_data[31:0] = 32'h99;
      if_valid = 1'b1; if_pc = 32'hbfc00008; if_inst = ADDU_3_0_0;
      #1;
      chk("lu_vsrc2_fwd",     64'(id_vsrc2),        64'h99);
      chk("lu_released",      64'(id_hazard),       64'd0);
      chk("lu_issue",         64'(id_to_exe_valid), 64'd1);
      chk("lu_allowin_again", 64'(id_allowin),      64'd1);
      step();
      if_valid = 1'b0; exe_allowin = 1'b0;
      chk("lu_cnt_stays", 64'(stall_cnt), 64'd3);
      chk("next_pc",      64'(id_pc),     64'hbfc00008);

      // Channel claims $0, not ready: reads of $0 stay zero, no hazard
      set_chan(0, 1'b1, 5'd0, 1'b0, 32'hdead);
      #1;
      chk("r0_vsrc1",  64'(id_vsrc1),  64'd0);
      chk("r0_vsrc2",  64'(id_vsrc2),  64'd0);
      chk("r0_hazard", 64'(id_hazard), 64'd0);

      // Reload ADDU $3,$1,$2 and stall it on $2
      exe_allowin = 1'b1; if_valid = 1'b1; if_pc = 32'hbfc0000c; if_inst = ADDU_3_1_2;
      fwd_valid = '0;
      step();
      if_valid = 1'b0; exe_allowin = 1'b0;
      set_chan(0, 1'b1, 5'd2, 1'b0, 32'h0);
      step();
      chk("st_hazard", 64'(id_hazard), 64'd1);
      chk("st_cnt4",   64'(stall_cnt), 64'd4);

      // Flush with a fetch in flight while stalled
      flush = 1'b1; if_valid = 1'b1; if_pc = 32'hbfc00010; if_inst = ADDU_3_0_0;
      #1;
      chk("fl_to_exe_valid_now", 64'(id_to_exe_valid), 64'd0);
      step();
      flush = 1'b0; if_valid = 1'b0;
      #1;
      chk("fl_cnt_unchanged",   64'(stall_cnt),       64'd4);
      chk("fl_to_exe_valid",    64'(id_to_exe_valid), 64'd0);
      chk("fl_id_empty",        64'(id_allowin),      64'd1);
      chk("fl_no_hazard",       64'(id_hazard),       64'd0);

      // Long stall: 4-bit counter saturates, 16-bit keeps counting
      exe_allowin = 1'b1; if_valid = 1'b1; if_pc = 32'hbfc00014; if_inst = ADDU_3_1_2;
      step();
      if_valid = 1'b0; exe_allowin = 1'b0;
      step(20);
      chk("sat_small_cnt", 64'(s_stall_cnt), 64'd15);
      chk("sat_big_cnt",   64'(stall_cnt),   64'd24);
      chk("sat_pc_held",   64'(id_pc),       64'hbfc00014);

      // Reset during the stall clears everything
      resetn = 1'b0;
      step();
      chk("rst2_small_cnt",   64'(s_stall_cnt),     64'd0);
      chk("rst2_big_cnt",     64'(stall_cnt),       64'd0);
      chk("rst2_to_exe",      64'(id_to_exe_valid), 64'd0);
      chk("rst2_hazard",      64'(id_hazard),       64'd0);
      chk("rst2_allowin",     64'(id_allowin),      64'd1);
      chk("rst2_pc",          64'(id_pc),           64'hbfc00000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
